// File: rtl/alu_exec.sv
// Execution stage for one ALU reservation-station slot: accepts a ready entry,
// executes it, then broadcasts on the CDB or reports a branch outcome.
// Optional macro ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec #(
  parameter int                 TAG_W    = 4,
  parameter logic [TAG_W-1:0]   UNLOCKED = '0,
  parameter int                 OP_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rs_busy,
  input  logic [31:0]      rs_pc,
  input  logic [OP_W-1:0]  rs_op,
  input  logic [TAG_W-1:0] rs_tagx,
  input  logic [TAG_W-1:0] rs_tagy,
  input  logic [31:0]      rs_datax,
  input  logic [31:0]      rs_datay,
  input  logic [31:0]      rs_imm,
  input  logic [TAG_W-1:0] rs_tagw,
  input  logic [4:0]       rs_target,
  output logic             exec_busy,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [31:0]      cdb_data,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [4:0]       cdb_target,
  output logic             br_valid,
  output logic             br_taken,
  output logic [31:0]      br_pc,
  output logic [31:0]      br_dest
);

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(15);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAITCDB} state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [OP_W-1:0]   op_p1;
  logic [4:0]        cnt_p1;
  logic [31:0]       result_p1;
  logic [TAG_W-1:0]  tagw_p1;
  logic [4:0]        target_p1;
  logic              br_vld_p1;
  logic              br_taken_p1;
  logic [31:0]       br_pc_p1;
  logic [31:0]       br_dest_p1;

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_branch = 1'b1;
      default:                                          is_branch = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

  // Iterative mode loads the unshifted operand here; SHIFT then walks it.
  function automatic logic [31:0] alu_result(input logic [OP_W-1:0] op,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    alu_result = x;
    case (op)
      OP_ADD:  alu_result = x + y;
      OP_SUB:  alu_result = x - y;
      OP_SLT:  alu_result = {31'd0, sx < sy};
      OP_SLTU: alu_result = {31'd0, x < y};
      OP_XOR:  alu_result = x ^ y;
      OP_OR:   alu_result = x | y;
      OP_AND:  alu_result = x & y;
      OP_SLL:  if (FAST_SHIFT) alu_result = x << y[4:0];
      OP_SRL:  if (FAST_SHIFT) alu_result = x >> y[4:0];
      OP_SRA:  if (FAST_SHIFT) alu_result = sx >>> y[4:0];
      default: alu_result = x;
    endcase
  endfunction

  function automatic logic br_eval(input logic [OP_W-1:0] op,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    case (op)
      OP_BEQ:  br_eval = (x == y);
      OP_BNE:  br_eval = (x != y);
      OP_BLT:  br_eval = (sx < sy);
      OP_BGE:  br_eval = (sx >= sy);
      OP_BLTU: br_eval = (x < y);
      OP_BGEU: br_eval = (x >= y);
      default: br_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] shift_step(input logic [OP_W-1:0] op,
                                             input logic [31:0] v);
    case (op)
      OP_SLL:  shift_step = {v[30:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, v[31:1]};
      OP_SRA:  shift_step = {v[31], v[31:1]};
      default: shift_step = v;
    endcase
  endfunction

  assign accept = (state == S_IDLE) && rs_busy && !flush &&
                  (rs_tagx == UNLOCKED) && (rs_tagy == UNLOCKED);

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_branch(rs_op))                    state_nxt = S_IDLE;
            else if (is_shift(rs_op) && !FAST_SHIFT) state_nxt = S_SHIFT;
            else                                     state_nxt = S_WAITCDB;
          end
        end
        S_SHIFT:   if (cnt_p1 <= 5'd1) state_nxt = S_WAITCDB;
        S_WAITCDB: if (cdb_grant)      state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p1: entry latched at accept; result refined in SHIFT, held in WAITCDB.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1   <= '0;
      tagw_p1     <= '0;
      target_p1   <= '0;
      br_vld_p1   <= 1'b0;
      br_taken_p1 <= 1'b0;
      br_pc_p1    <= '0;
      br_dest_p1  <= '0;
    end else if (rdy) begin
      br_vld_p1 <= 1'b0;
      if (accept) begin
        op_p1     <= rs_op;
        cnt_p1    <= rs_datay[4:0];
        tagw_p1   <= rs_tagw;
        target_p1 <= rs_target;
        if (is_branch(rs_op)) begin
          br_vld_p1   <= 1'b1;
          br_taken_p1 <= br_eval(rs_op, rs_datax, rs_datay);
          br_pc_p1    <= rs_pc;
          br_dest_p1  <= rs_pc + rs_imm;
        end else begin
          result_p1 <= alu_result(rs_op, rs_datax, rs_datay);
        end
      end else if (state == S_SHIFT && !flush && cnt_p1 != 5'd0) begin
        result_p1 <= shift_step(op_p1, result_p1);
        cnt_p1    <= cnt_p1 - 5'd1;
      end
    end
  end

  always_comb begin
    cdb_req    = (state == S_WAITCDB);
    exec_busy  = (state != S_IDLE);
    br_valid   = br_vld_p1 && rdy;
    br_taken   = br_taken_p1;
    br_pc      = br_pc_p1;
    br_dest    = br_dest_p1;
    cdb_data   = result_p1;
    cdb_tag    = tagw_p1;
    cdb_target = target_p1;
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against a transaction-level model.
module tb_alu_exec;
  localparam int TAG_W = 4;
  localparam int OP_W  = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, flush, rs_busy;
  logic [31:0]      rs_pc, rs_datax, rs_datay, rs_imm;
  logic [OP_W-1:0]  rs_op;
  logic [TAG_W-1:0] rs_tagx, rs_tagy, rs_tagw;
  logic [4:0]       rs_target;
  logic             exec_busy, cdb_req, cdb_grant;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] cdb_tag;
  logic [4:0]       cdb_target;
  logic             br_valid, br_taken;
  logic [31:0]      br_pc, br_dest;

  int n_chk  = 0;
  int n_pass = 0;

  alu_exec #(.TAG_W(TAG_W), .UNLOCKED('0), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rs_busy(rs_busy),
    .rs_pc(rs_pc), .rs_op(rs_op), .rs_tagx(rs_tagx), .rs_tagy(rs_tagy),
    .rs_datax(rs_datax), .rs_datay(rs_datay), .rs_imm(rs_imm),
    .rs_tagw(rs_tagw), .rs_target(rs_target), .exec_busy(exec_busy),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_target(cdb_target), .br_valid(br_valid),
    .br_taken(br_taken), .br_pc(br_pc), .br_dest(br_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] x, input logic [31:0] y);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint p  = longint'(1) << int'(y[4:0]);
    longint q;
    case (op)
      0: return 32'(ux + uy);
      1: return 32'(ux - uy);
      2: return 32'(ux * p);
      3: return (sx < sy) ? 32'd1 : 32'd0;
      4: return (ux < uy) ? 32'd1 : 32'd0;
      5: return x ^ y;
      6: return 32'(ux / p);
      7: begin
        q = sx / p;
        if (sx < 0 && (sx % p) != 0) q = q - 1;
        return 32'(q);
      end
      8: return x | y;
      9: return x & y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input int op, input logic [31:0] x, input logic [31:0] y);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (op)
      10: return ux == uy;
      11: return ux != uy;
      12: return sx < sy;
      13: return sx >= sy;
      14: return ux < uy;
      15: return ux >= uy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_latency(input int op, input logic [31:0] y);
    int sh = int'(y[4:0]);
    if (op == 2 || op == 6 || op == 7) begin
`ifdef ALU_FAST_SHIFT_EN
      return 1;
`else
      return ((sh == 0) ? 1 : sh) + 1;
`endif
    end
    return 1;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_cdb_req"},    32'(cdb_req),    32'd0);
    check({pfx, "_exec_busy"},  32'(exec_busy),  32'd0);
    check({pfx, "_br_valid"},   32'(br_valid),   32'd0);
    check({pfx, "_cdb_data"},   cdb_data,        32'd0);
    check({pfx, "_cdb_tag"},    32'(cdb_tag),    32'd0);
    check({pfx, "_cdb_target"}, 32'(cdb_target), 32'd0);
    check({pfx, "_br_taken"},   32'(br_taken),   32'd0);
    check({pfx, "_br_pc"},      br_pc,           32'd0);
    check({pfx, "_br_dest"},    br_dest,         32'd0);
  endtask

  task automatic present(input int op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [3:0] tagw, input logic [4:0] tgt);
    rs_op = 4'(op); rs_datax = x; rs_datay = y; rs_pc = pc; rs_imm = imm;
    rs_tagw = tagw; rs_target = tgt; rs_tagx = '0; rs_tagy = '0; rs_busy = 1'b1;
  endtask

  // One full transaction; lock delays the operands, gdelay withholds the grant.
  task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [3:0] tagw, input logic [4:0] tgt,
                        input int lock, input int gdelay);
    logic [31:0] exp;
    int lat, k;
    present(op, x, y, pc, imm, tagw, tgt);
    for (int i = 0; i < lock; i++) begin
      if ($urandom_range(0, 1) == 0) rs_tagx = 4'(i + 1);
      else                           rs_tagy = 4'(i + 1);
      tick();
      check("lock_busy", 32'(exec_busy), 32'd0);
      check("lock_req", 32'(cdb_req), 32'd0);
    end
    rs_tagx = '0; rs_tagy = '0;
    tick();
    rs_busy = 1'b0; rs_tagx = 4'($urandom); rs_tagy = 4'($urandom);
    if (op >= 10) begin
      check("br_valid", 32'(br_valid), 32'd1);
      check("br_taken", 32'(br_taken), 32'(ref_taken(op, x, y)));
      check("br_pc", br_pc, pc);
      check("br_dest", br_dest, pc + imm);
      check("br_no_req", 32'(cdb_req), 32'd0);
      check("br_busy_low", 32'(exec_busy), 32'd0);
      tick();
      check("br_pulse_end", 32'(br_valid), 32'd0);
      check("br_no_req2", 32'(cdb_req), 32'd0);
    end else begin
      exp = ref_result(op, x, y);
      lat = ref_latency(op, y);
      k = 1;
      while (!cdb_req && k < 64) begin
        cdb_grant = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      check("latency", 32'(k), 32'(lat));
      check("cdb_data", cdb_data, exp);
      check("cdb_tag", 32'(cdb_tag), 32'(tagw));
      check("cdb_target", 32'(cdb_target), 32'(tgt));
      check("busy_wait", 32'(exec_busy), 32'd1);
      for (int d = 0; d < gdelay; d++) begin
        cdb_grant = 1'b0;
        tick();
        check("hold_req", 32'(cdb_req), 32'd1);
        check("hold_data", cdb_data, exp);
        check("hold_busy", 32'(exec_busy), 32'd1);
      end
      cdb_grant = 1'b1;
      tick();
      cdb_grant = 1'b0;
      check("release_req", 32'(cdb_req), 32'd0);
      check("release_busy", 32'(exec_busy), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] x, y, held;
    int op;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
    present(0, '0, '0, '0, '0, '0, '0);
    rs_busy = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    run_op(0,  32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 4'd5, 5'd3, 0, 0);
    run_op(7,  32'h8000_0000, 32'd4, 32'h0, 32'h0, 4'd6, 5'd7, 0, 0);
    run_op(14, 32'd1, 32'hFFFF_FFFF, 32'h100, 32'h20, 4'd1, 5'd1, 0, 0);
    run_op(1,  32'd3, 32'd5, 32'h0, 32'h0, 4'd9, 5'd12, 3, 0);
    run_op(5,  32'h1234_5678, 32'hFFFF_0000, 32'h0, 32'h0, 4'd2, 5'd30, 0, 4);
    run_op(2,  32'h0000_0001, 32'd0, 32'h0, 32'h0, 4'd4, 5'd4, 0, 0);
    run_op(12, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h20, 4'd0, 5'd0, 0, 0);

    // Flush while a long shift is in flight.
    present(6, 32'hF000_0000, 32'd20, 32'h0, 32'h0, 4'd7, 5'd9);
    tick();
    rs_busy = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_flush_busy", 32'(exec_busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req", 32'(cdb_req), 32'd0);
    check("flush_busy", 32'(exec_busy), 32'd0);
    check("flush_brv", 32'(br_valid), 32'd0);

    // A ready entry must not be taken in a flush cycle.
    present(0, 32'd1, 32'd1, 32'h0, 32'h0, 4'd3, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rs_busy = 1'b0;
    check("flush_noaccept", 32'(exec_busy), 32'd0);
    run_op(3, 32'h8000_0000, 32'd1, 32'h0, 32'h0, 4'd8, 5'd8, 0, 1);

    // Reset while waiting for the bus.
    present(9, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0, 4'd15, 5'd31);
    tick();
    rs_busy = 1'b0;
    check("pre_rst_req", 32'(cdb_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    run_op(8, 32'hA000_0000, 32'h0000_000A, 32'h0, 32'h0, 4'd11, 5'd17, 0, 0);

    // rdy low freezes the slot even with grant asserted.
    present(4, 32'd7, 32'hFFFF_FFF0, 32'h0, 32'h0, 4'd12, 5'd2);
    tick();
    rs_busy = 1'b0;
    held = cdb_data;
    check("rdy_pre_data", held, 32'd1);
    rdy = 1'b0;
    cdb_grant = 1'b1;
    tick();
    tick();
    check("rdy_hold_req", 32'(cdb_req), 32'd1);
    check("rdy_hold_busy", 32'(exec_busy), 32'd1);
    check("rdy_hold_data", cdb_data, held);
    rdy = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check("rdy_release", 32'(cdb_req), 32'd0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 15);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      if ($urandom_range(0, 3) == 0) x = {x[31], 31'd0} | (x & 32'h0000_00FF);
      run_op(op, x, y, $urandom, $urandom, 4'($urandom), 5'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution stage directly downstream of the ALU reservation station; one instance per RS slot.
- Watches its slot. Once both operand tags read UNLOCKED, it latches the entry, executes it, and either broadcasts the result on the common data bus (CDB) or reports a branch outcome.
- Drives the per-slot exec-busy signal back into the reservation station, which uses it to free the slot.

Parameters:
- TAG_W, 4, register tag width.
- UNLOCKED, 0, tag value meaning "operand ready".
- OP_W, 4, op field width.

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low = hold all state
- flush  in  1  mispredict squash; abort current op
- rs_busy  in  1  RS slot holds a valid entry
- rs_pc  in  32  instruction PC
- rs_op  in  OP_W  op code (encoding below)
- rs_tagx, rs_tagy  in  TAG_W  operand tags
- rs_datax, rs_datay  in  32  operand values
- rs_imm  in  32  branch offset
- rs_tagw  in  TAG_W  destination tag
- rs_target  in  5  destination register
- exec_busy  out  1  high from accept through grant cycle
- cdb_req  out  1  result valid, request CDB
- cdb_grant  in  1  CDB arbiter accepts this cycle
- cdb_data  out  32  result
- cdb_tag  out  TAG_W  destination tag
- cdb_target  out  5  destination register
- br_valid  out  1  one-cycle branch-resolved pulse
- br_taken  out  1  branch outcome
- br_pc  out  32  pc of resolved branch
- br_dest  out  32  pc+imm

Behaviour:
- Op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- FSM states: IDLE, SHIFT, WAITCDB.
- Reset (rst=1 at posedge): state=IDLE; all outputs 0, including cdb_tag and all data outputs.
- rdy=0: state and all registers hold; br_valid forced 0.
- IDLE: accept when rs_busy and rs_tagx==UNLOCKED and rs_tagy==UNLOCKED. On accept, latch pc, op, operands, imm, tagw and target; exec_busy<=1.
  - Op 0,1,3-5,8,9 (single-cycle): compute in the accept cycle, register the result, go to WAITCDB. cdb_req rises the next cycle (latency 1).
  - Shifts (2,6,7): shamt = datay[4:0]. Go to SHIFT with a counter equal to shamt.
  - Branches (10-15): br_valid=1 for exactly one cycle in the cycle after accept, with br_taken, br_pc and br_dest=pc+imm (mod 2^32). Return to IDLE; exec_busy low in that same cycle. No CDB request.
- SHIFT: one bit per cycle; counter decrements. On reaching 0, go to WAITCDB. shamt=0 spends one SHIFT cycle, so total latency is max(shamt,1)+1. SRA replicates bit 31.
- WAITCDB: cdb_req=1; cdb_data, cdb_tag and cdb_target held stable until the cycle with cdb_grant=1. In that cycle exec_busy=1. Next cycle: IDLE, cdb_req=0, exec_busy=0.
- An accept in the first IDLE cycle after a grant is allowed (back-to-back).
- SLT/BLT/BGE use signed compare; SLTU/BLTU/BGEU use unsigned compare. SUB wraps mod 2^32.
- flush=1 (rst=0): state=IDLE, cdb_req=0, exec_busy=0, br_valid=0 next cycle. No accept in the flush cycle.
- Priority: rst > flush > grant/accept.
- cdb_grant while cdb_req=0 is ignored.

Optional Feature:
- ALU_FAST_SHIFT_EN defined: shifts use a barrel shifter, complete in the accept cycle, and take the single-cycle path; the SHIFT state is unreachable.
- Undefined: iterative shifter as described under Behaviour.

Test Plan:
- ADD, datax=0xFFFFFFFF, datay=2, tags UNLOCKED, tagw=5, target=3, cdb_grant tied 1 -> cdb_req at accept+1 with data=0x00000001, tag=5, target=3; exec_busy low at accept+2.
- SRA, datax=0x80000000, datay=4, grant tied 1 -> cdb_req at accept+5, data=0xF8000000. With ALU_FAST_SHIFT_EN: accept+1.
- BLTU, x=1, y=0xFFFFFFFF, pc=0x100, imm=0x20 -> br_valid pulse at accept+1, taken=1, br_dest=0x120; cdb_req never asserted.
- rs_tagy≠UNLOCKED for 3 cycles, then UNLOCKED -> no accept until the tag clears, exec_busy 0 meanwhile; the op completes normally afterwards.
- cdb_grant withheld 4 cycles -> cdb_req, cdb_data and exec_busy stable throughout; release one cycle after grant.
- Flush during SHIFT (shamt=20), and separately rst mid-WAITCDB -> outputs zero / IDLE next cycle; new entry accepted afterwards.
